// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate engine: applies one single-bit shift or rotate per
// clock for a captured number of steps, with a start/busy/done handshake.
module shift_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic             s3,
    input  logic             s2,
    input  logic [CNT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_SHL = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             cout_q, cout_d;

    // One step of the latched operation, plus the bit it pushes out of the word.
    logic [WIDTH-1:0] stepWord;
    logic             stepOut;

    always_comb begin
        stepWord = work_q;
        stepOut  = 1'b0;
        case (op_q)
            OP_ROR: begin
                stepWord = {work_q[0], work_q[WIDTH-1:1]};
                stepOut  = work_q[0];
            end
            OP_SHR: begin
                stepWord = {1'b0, work_q[WIDTH-1:1]};
                stepOut  = work_q[0];
            end
            OP_ROL: begin
                stepWord = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                stepOut  = work_q[WIDTH-1];
            end
            OP_SHL: begin
                stepWord = {work_q[WIDTH-2:0], 1'b0};
                stepOut  = work_q[WIDTH-1];
            end
            default: begin
                stepWord = work_q;
                stepOut  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = A;
                    cnt_d   = amount;
                    op_d    = {s3, s2};
                    cout_d  = 1'b0;
                    state_d = (amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = stepWord;
                cout_d = stepOut;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchronous reset wins over start and clears any captured operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            cout_q  <= cout_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign result = work_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed testbench for shift_seq: table of single operations plus
// hand-written sequences for held start and reset during a shift.
module tb_shift_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
    localparam int MAX_WAIT = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic             s3;
    logic             s2;
    logic [CNT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    int testsRun    = 0;
    int testsFailed = 0;

    shift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .s3     (s3),
        .s2     (s2),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [1:0]       op;
        logic [CNT_W-1:0] amt;
        logic [WIDTH-1:0] expResult;
        logic             expCout;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one request for a single cycle, then scrambles the operand inputs
    // so only the latched copies can produce the right answer.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [1:0] op,
                                 input logic [CNT_W-1:0] amt);
        @(negedge clk);
        A      = a;
        {s3, s2} = op;
        amount = amt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        A      = ~a;
        {s3, s2} = ~op;
        amount = ~amt;
    endtask

    // Called at the first negedge after the accepting edge; returns at the
    // negedge where done is seen (cycle index 1 = cycle after the accepting edge).
    task automatic waitDone(output int busyCycles, output int doneAt, output bit timedOut);
        int i;
        busyCycles = 0;
        doneAt     = 0;
        timedOut   = 1'b1;
        i          = 1;
        while (i <= MAX_WAIT && timedOut) begin
            if (done === 1'b1) begin
                doneAt   = i;
                timedOut = 1'b0;
            end else begin
                if (busy === 1'b1) busyCycles++;
                @(negedge clk);
                i++;
            end
        end
    endtask

    task automatic runVector(input vec_t v);
        int  busyCycles;
        int  doneAt;
        bit  timedOut;
        applyStimulus(v.a, v.op, v.amt);
        waitDone(busyCycles, doneAt, timedOut);
        checkOutput({v.name, " timeout"}, 32'(timedOut), 32'd0);
        checkOutput({v.name, " latency"}, 32'(doneAt), 32'(v.amt) + 32'd1);
        checkOutput({v.name, " busyCycles"}, 32'(busyCycles), 32'(v.amt));
        checkOutput({v.name, " result"}, 32'(result), 32'(v.expResult));
        checkOutput({v.name, " cout"}, 32'(cout), 32'(v.expCout));
        @(negedge clk);
        checkOutput({v.name, " doneWidth"}, 32'(done), 32'd0);
        checkOutput({v.name, " idleBusy"}, 32'(busy), 32'd0);
        checkOutput({v.name, " resultHeld"}, 32'(result), 32'(v.expResult));
        checkOutput({v.name, " coutHeld"}, 32'(cout), 32'(v.expCout));
    endtask

    initial begin
        int  busyCycles;
        int  doneAt;
        bit  timedOut;
        int  strayDone;
        int  strayBusy;

        vecs[0] = '{"shl96x3",  8'h96, 2'b11, 3'd3, 8'hB0, 1'b0};
        vecs[1] = '{"shr96x2",  8'h96, 2'b01, 3'd2, 8'h25, 1'b1};
        vecs[2] = '{"rol96x7",  8'h96, 2'b10, 3'd7, 8'h4B, 1'b1};
        vecs[3] = '{"ror81x1",  8'h81, 2'b00, 3'd1, 8'hC0, 1'b1};
        vecs[4] = '{"amt0_5A",  8'h5A, 2'b00, 3'd0, 8'h5A, 1'b0};
        vecs[5] = '{"ror96x3",  8'h96, 2'b00, 3'd3, 8'hD2, 1'b1};
        vecs[6] = '{"shr80x7",  8'h80, 2'b01, 3'd7, 8'h01, 1'b0};
        vecs[7] = '{"shlFFx7",  8'hFF, 2'b11, 3'd7, 8'h80, 1'b1};
        vecs[8] = '{"rol81x1",  8'h81, 2'b10, 3'd1, 8'h03, 1'b1};
        vecs[9] = '{"shrFFx7",  8'hFF, 2'b01, 3'd7, 8'h01, 1'b1};

        rst    = 1'b1;
        start  = 1'b0;
        A      = '0;
        s3     = 1'b0;
        s2     = 1'b0;
        amount = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) runVector(vecs[i]);

        // Start held high across a whole operation with the operand changed
        // mid-shift: the second request is only taken in IDLE after DONE.
        @(negedge clk);
        A = 8'h96; {s3, s2} = 2'b11; amount = 3'd3; start = 1'b1;
        @(negedge clk);
        A = 8'hFF; {s3, s2} = 2'b01; amount = 3'd2;
        waitDone(busyCycles, doneAt, timedOut);
        checkOutput("held timeout", 32'(timedOut), 32'd0);
        checkOutput("held latency", 32'(doneAt), 32'd4);
        checkOutput("held busyCycles", 32'(busyCycles), 32'd3);
        checkOutput("held result", 32'(result), 32'hB0);
        checkOutput("held cout", 32'(cout), 32'd0);
        @(negedge clk);
        checkOutput("held idleBusy", 32'(busy), 32'd0);
        checkOutput("held idleDone", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("held secondAccepted", 32'(busy), 32'd1);
        waitDone(busyCycles, doneAt, timedOut);
        checkOutput("second timeout", 32'(timedOut), 32'd0);
        checkOutput("second latency", 32'(doneAt), 32'd3);
        checkOutput("second result", 32'(result), 32'h3F);
        checkOutput("second cout", 32'(cout), 32'd1);
        @(negedge clk);

        // Reset in the middle of a rotate, with start asserted alongside it.
        applyStimulus(8'h96, 2'b10, 3'd7);
        @(negedge clk);
        checkOutput("midReset preBusy", 32'(busy), 32'd1);
        rst = 1'b1;
        A = 8'h11; {s3, s2} = 2'b11; amount = 3'd5; start = 1'b1;
        @(negedge clk);
        checkOutput("midReset busy", 32'(busy), 32'd0);
        checkOutput("midReset done", 32'(done), 32'd0);
        checkOutput("midReset result", 32'(result), 32'd0);
        checkOutput("midReset cout", 32'(cout), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        strayDone = 0;
        strayBusy = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) strayDone++;
            if (busy === 1'b1) strayBusy++;
        end
        checkOutput("postReset strayDone", 32'(strayDone), 32'd0);
        checkOutput("postReset strayBusy", 32'(strayBusy), 32'd0);
        checkOutput("postReset result", 32'(result), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
